// File: rtl/packet_pkg.sv
// Shared port-level types for the 4-port packet switch: masks, indices and
// the per-input allocation state used by the switch allocator.
package packet_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [1:0]           port_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STARVED,
    ACTIVE
  } alloc_state_e;

  localparam logic [3:0] WAIT_CNT_MAX = 4'd15;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: returns the first eligible entry
// found when scanning upward (with wrap) from rr_ptr.
module rr_pick4
  import packet_pkg::*;
(
  input  port_mask_t eligible,
  input  port_idx_t  rr_ptr,
  output port_mask_t pick,
  output logic       valid
);

  port_idx_t idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + port_idx_t'(k);
      if (!valid && eligible[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// All-or-nothing output allocator for the 4-port switch: one grant per cycle,
// round-robin among waiting inputs, with a single starvation token that
// reserves the starved input's outputs until it is served.
module switch_allocator
  import packet_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  port_mask_t                  req_valid,
  input  port_mask_t [NUM_PORTS-1:0]  req_mask,
  input  port_mask_t                  done,
  output port_mask_t                  grant,
  output port_mask_t                  out_busy,
  output port_idx_t  [NUM_PORTS-1:0]  out_owner,
  output port_mask_t                  req_err
);

  alloc_state_e state_q    [NUM_PORTS];
  alloc_state_e state_d    [NUM_PORTS];
  logic [3:0]   wait_cnt_q [NUM_PORTS];
  logic [3:0]   wait_cnt_d [NUM_PORTS];
  port_mask_t   reserved   [NUM_PORTS];

  port_idx_t                 rr_ptr_q;
  port_idx_t                 rr_ptr_d;
  port_mask_t                busy_d;
  port_idx_t [NUM_PORTS-1:0] owner_d;
  port_mask_t                err_d;
  port_mask_t                eligible;
  port_mask_t                wait_eligible;
  port_mask_t                starved_eligible;
  port_mask_t                rr_pick;
  port_mask_t                grant_vec;
  port_idx_t                 grant_idx;
  logic                      rr_valid;
  logic                      token_held;
  logic                      starve_claim;

  // Outputs reserved by a starved input are off-limits to everyone else.
  always_comb begin
    token_held       = 1'b0;
    eligible         = '0;
    wait_eligible    = '0;
    starved_eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      reserved[i] = '0;
      if (state_q[i] == STARVED) token_held = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (k != i && state_q[k] == STARVED && req_valid[k])
          reserved[i] = reserved[i] | req_mask[k];
      end
      eligible[i] = (state_q[i] == WAIT || state_q[i] == STARVED) && req_valid[i] &&
                    (req_mask[i] != '0) &&
                    ((req_mask[i] & (out_busy | reserved[i])) == '0);
      wait_eligible[i]    = eligible[i] && (state_q[i] == WAIT);
      starved_eligible[i] = eligible[i] && (state_q[i] == STARVED);
    end
  end

  rr_pick4 u_rr_pick4 (
    .eligible (wait_eligible),
    .rr_ptr   (rr_ptr_q),
    .pick     (rr_pick),
    .valid    (rr_valid)
  );

  // Only one input can hold the token, so starved_eligible is at most one-hot.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    if (starved_eligible != '0) grant_vec = starved_eligible;
    else if (rr_valid)          grant_vec = rr_pick;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_vec[i]) grant_idx = port_idx_t'(i);
    end
  end

  always_comb begin
    busy_d       = out_busy;
    owner_d      = out_owner;
    rr_ptr_d     = rr_ptr_q;
    err_d        = '0;
    starve_claim = token_held;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i]    = state_q[i];
      wait_cnt_d[i] = wait_cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (req_valid[i]) begin
            if (req_mask[i] == '0) err_d[i] = 1'b1;
            else                   state_d[i] = WAIT;
          end
        end
        WAIT, STARVED: begin
          if (grant_vec[i]) begin
            state_d[i]    = ACTIVE;
            wait_cnt_d[i] = '0;
          end else if (!req_valid[i]) begin
            state_d[i]    = IDLE;
            wait_cnt_d[i] = '0;
          end else begin
            if (wait_cnt_q[i] != WAIT_CNT_MAX) wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
            // Lowest index wins if several inputs hit the limit together.
            if (state_q[i] == WAIT && !starve_claim &&
                int'(wait_cnt_q[i]) >= STARVE_LIMIT) begin
              state_d[i]   = STARVED;
              starve_claim = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (done[i]) begin
            state_d[i] = IDLE;
            for (int j = 0; j < NUM_PORTS; j++) begin
              if (out_busy[j] && out_owner[j] == port_idx_t'(i)) begin
                busy_d[j]  = 1'b0;
                owner_d[j] = '0;
              end
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
    if (grant_vec != '0) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (req_mask[grant_idx][j]) begin
          busy_d[j]  = 1'b1;
          owner_d[j] = grant_idx;
        end
      end
      rr_ptr_d = grant_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]    <= IDLE;
        wait_cnt_q[i] <= '0;
      end
      rr_ptr_q  <= '0;
      grant     <= '0;
      out_busy  <= '0;
      out_owner <= '0;
      req_err   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]    <= state_d[i];
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
      rr_ptr_q  <= rr_ptr_d;
      grant     <= grant_vec;
      out_busy  <= busy_d;
      out_owner <= owner_d;
      req_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_switch_allocator;

  localparam int LIMIT     = 8;
  localparam int S_IDLE    = 0;
  localparam int S_WAIT    = 1;
  localparam int S_STARVED = 2;
  localparam int S_ACTIVE  = 3;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][3:0] req_mask;
  logic [3:0]      done;
  logic [3:0]      grant;
  logic [3:0]      out_busy;
  logic [3:0][1:0] out_owner;
  logic [3:0]      req_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per-input state, wait count, owner per output (-1 free), token holder.
  int         m_st   [4];
  int         m_wait [4];
  int         m_own  [4];
  int         m_rr;
  int         m_starver;
  logic [3:0] m_grant;
  logic [3:0] m_err;
  int         age    [4];

  switch_allocator #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_mask  (req_mask),
    .done      (done),
    .grant     (grant),
    .out_busy  (out_busy),
    .out_owner (out_owner),
    .req_err   (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = S_IDLE; m_wait[i] = 0; m_own[i] = -1;
    end
    m_rr = 0; m_starver = -1; m_grant = '0; m_err = '0;
  endtask

  task automatic model_step(input logic [3:0] rv, input logic [3:0][3:0] mk, input logic [3:0] dn);
    int nst [4]; int nwait [4]; bit elig [4];
    logic [3:0] busy, block;
    int winner, nstarver, c;
    busy = '0;
    for (int j = 0; j < 4; j++) if (m_own[j] >= 0) busy[j] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      block = busy;
      if (m_starver >= 0 && m_starver != i && rv[m_starver]) block = block | mk[m_starver];
      elig[i] = (m_st[i] == S_WAIT || m_st[i] == S_STARVED) && rv[i] && mk[i] != 4'd0 &&
                ((mk[i] & block) == 4'd0);
    end
    winner = -1;
    if (m_starver >= 0 && elig[m_starver]) winner = m_starver;
    else
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (winner < 0 && elig[c] && m_st[c] == S_WAIT) winner = c;
      end
    m_grant = '0; m_err = '0; nstarver = m_starver;
    for (int i = 0; i < 4; i++) begin
      nst[i] = m_st[i]; nwait[i] = m_wait[i];
      if (m_st[i] == S_IDLE) begin
        if (rv[i]) begin
          if (mk[i] == 4'd0) m_err[i] = 1'b1;
          else begin nst[i] = S_WAIT; nwait[i] = 0; end
        end
      end else if (m_st[i] == S_ACTIVE) begin
        if (dn[i]) begin
          nst[i] = S_IDLE;
          for (int j = 0; j < 4; j++) if (m_own[j] == i) m_own[j] = -1;
        end
      end else if (i == winner || !rv[i]) begin
        nst[i] = (i == winner) ? S_ACTIVE : S_IDLE;
        nwait[i] = 0;
        if (m_starver == i) nstarver = -1;
      end else begin
        if (m_st[i] == S_WAIT && m_starver < 0 && nstarver < 0 && m_wait[i] >= LIMIT) begin
          nst[i] = S_STARVED; nstarver = i;
        end
        nwait[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
      end
    end
    if (winner >= 0) begin
      for (int j = 0; j < 4; j++) if (mk[winner][j]) m_own[j] = winner;
      m_grant[winner] = 1'b1;
      m_rr = (winner + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin m_st[i] = nst[i]; m_wait[i] = nwait[i]; end
    m_starver = nstarver;
  endtask

  task automatic compare_all();
    logic [3:0]      eb;
    logic [3:0][1:0] eo;
    for (int j = 0; j < 4; j++) begin
      eb[j] = (m_own[j] >= 0);
      eo[j] = (m_own[j] >= 0) ? 2'(m_own[j]) : 2'd0;
    end
    check_output("model_grant", {4'd0, grant}, {4'd0, m_grant});
    check_output("model_busy", {4'd0, out_busy}, {4'd0, eb});
    check_output("model_owner", out_owner, eo);
    check_output("model_err", {4'd0, req_err}, {4'd0, m_err});
  endtask

  // Model advances on each rising edge with the inputs the DUT sampled.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(req_valid, req_mask, done);
      @(negedge clk);
      if (rst_n) compare_all();
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit all_idle;
    for (int n = 0; n < 30; n++) begin
      req_valid = '0;
      done      = '0;
      all_idle  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (m_st[i] == S_ACTIVE) done[i] = 1'b1;
        if (m_st[i] != S_IDLE) all_idle = 1'b0;
      end
      if (all_idle) break;
      tick();
    end
    done = '0;
    check_output("drain_busy", {4'd0, out_busy}, 8'h00);
  endtask

  task automatic apply_stimulus();
    logic [3:0] onehot;
    int r;
    done = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_st[i] == S_IDLE) begin
        req_valid[i] = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        onehot = 4'b0001 << $urandom_range(0, 3);
        if (r == 0)      req_mask[i] = 4'd0;
        else if (r <= 2) req_mask[i] = 4'hF;
        else if (r <= 5) req_mask[i] = onehot;
        else             req_mask[i] = 4'($urandom_range(1, 15));
      end else if (m_st[i] == S_ACTIVE) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        done[i] = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 39) == 0) begin
        req_valid[i] = 1'b0;
      end
      if (m_st[i] != S_ACTIVE && $urandom_range(0, 19) == 0) done[i] = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] seen;
    bit first, found;
    rst_n = 1'b0; req_valid = '0; req_mask = '0; done = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("reset_grant", {4'd0, grant}, 8'h00);
    check_output("reset_busy", {4'd0, out_busy}, 8'h00);
    check_output("reset_owner", out_owner, 8'h00);
    check_output("reset_err", {4'd0, req_err}, 8'h00);

    // Clash on 1100: input 0 wins from rr_ptr 0, input 1 follows its release.
    req_mask[0] = 4'b1100; req_mask[1] = 4'b1100; req_valid = 4'b0011;
    tick();
    check_output("clash_wait", {4'd0, grant}, 8'h00);
    tick();
    check_output("clash_grant0", {4'd0, grant}, 8'h01);
    check_output("clash_busy0", {4'd0, out_busy}, 8'h0C);
    check_output("clash_owner0", out_owner, 8'h00);
    req_valid[0] = 1'b0; done[0] = 1'b1;
    tick();
    done = '0;
    check_output("clash_release", {4'd0, out_busy}, 8'h00);
    tick();
    check_output("clash_grant1", {4'd0, grant}, 8'h02);
    check_output("clash_owner1", out_owner, 8'h50);
    req_valid[1] = 1'b0; done[1] = 1'b1;
    tick();
    done = '0;

    // Broadcast from input 2 blocked behind unicast owner input 3.
    req_mask[3] = 4'b0001; req_valid = 4'b1000;
    tick(); tick();
    check_output("bc_grant3", {4'd0, grant}, 8'h08);
    req_valid = 4'b0100; req_mask[2] = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_output("bc_blocked_grant", {4'd0, grant}, 8'h00);
      check_output("bc_blocked_busy", {4'd0, out_busy}, 8'h01);
    end
    done[3] = 1'b1;
    tick();
    done = '0;
    check_output("bc_freed", {4'd0, out_busy}, 8'h00);
    tick();
    check_output("bc_grant2", {4'd0, grant}, 8'h04);
    check_output("bc_busy2", {4'd0, out_busy}, 8'h0F);
    req_valid = '0; done[2] = 1'b1;
    tick();
    done = '0;

    // Empty mask is rejected; a withdrawn request never gets granted.
    req_mask[1] = 4'd0; req_valid = 4'b0010;
    tick();
    check_output("err_pulse", {4'd0, req_err}, 8'h02);
    check_output("err_nogrant", {4'd0, grant}, 8'h00);
    req_valid = '0;
    tick();
    check_output("err_clear", {4'd0, req_err}, 8'h00);
    req_mask[0] = 4'b0001; req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check_output("withdraw_grant", {4'd0, grant}, 8'h00);
    tick();
    check_output("withdraw_busy", {4'd0, out_busy}, 8'h00);

    // Three overlapping requests are served one at a time, input 3 first.
    req_mask[0] = 4'b0110; req_mask[1] = 4'b1100; req_mask[3] = 4'b1010;
    req_valid = 4'b1011; seen = '0; first = 1'b1;
    for (int n = 0; n < 40 && seen != 4'b1011; n++) begin
      tick();
      seen = seen | grant;
      check_output("three_onehot", {7'd0, ($countones(grant) <= 1)}, 8'h01);
      if (first && grant != '0) begin
        check_output("three_first", {4'd0, grant}, 8'h08);
        first = 1'b0;
      end
      done = '0;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) req_valid[i] = 1'b0;
        else if (m_st[i] == S_ACTIVE) done[i] = 1'b1;
      end
    end
    check_output("three_all", {4'd0, seen}, 8'h0B);
    drain();

    // Broadcast starved by alternating unicasts until the token protects it.
    req_mask[0] = 4'b0001; req_mask[1] = 4'b0010; req_mask[2] = 4'b1111;
    req_valid = 4'b0001; found = 1'b0;
    age[0] = 0; age[1] = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      tick();
      if (grant[2]) begin
        found = 1'b1;
        check_output("starve_busy", {4'd0, out_busy}, 8'h0F);
      end
      if (n == 1) req_valid = 4'b0111;
      done = '0;
      for (int i = 0; i < 2; i++) begin
        age[i] = (m_st[i] == S_ACTIVE) ? age[i] + 1 : 0;
        if (age[i] == 3) done[i] = 1'b1;
      end
    end
    check_output("starve_granted", {7'd0, found}, 8'h01);
    drain();

    // Asynchronous reset drops ownership immediately.
    req_mask[2] = 4'b1111; req_valid = 4'b0100;
    tick(); tick();
    check_output("rst_pre_busy", {4'd0, out_busy}, 8'h0F);
    req_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("rst_busy", {4'd0, out_busy}, 8'h00);
    check_output("rst_owner", out_owner, 8'h00);
    req_mask[1] = 4'd0; req_valid = 4'b0010;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("rst_post_grant", {4'd0, grant}, 8'h00);
    check_output("rst_post_err", {4'd0, req_err}, 8'h00);
    tick();
    check_output("rst_first_err", {4'd0, req_err}, 8'h02);
    req_valid = '0;
    tick();

    for (int n = 0; n < 1500; n++) begin
      apply_stimulus();
      tick();
    end
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
